sccb_slave_responder: RTL

//  SCCB target (camera side) that answers the bus driven by our sccb_master/ov2640_init pair.
//  - Oversamples SIO_C/SIO_D on clk_in and decodes 3-phase writes, 2-phase writes and 2-phase reads.
//  - Writes go to an external register file; reads return a byte from it.
//  - Used as an OV2640 stand-in for FPGA loopback and for simulation of the init sequence.

---
 rtl/sccb_slave_responder.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/sccb_slave_responder.sv
// SCCB target (OV2640 stand-in): decodes 3-phase/2-phase writes and 2-phase reads.
// Optional I2C-style ACK on the 9th bit when SCCB_SLAVE_ACK_EN is defined.
module sccb_slave_responder #(
  parameter logic [6:0]  DEV_ADDRESS = 7'h30,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       sio_c_in,
  input  logic       sio_d_in,
  output logic       sio_d_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wr_data,
  output logic       reg_wr_en,
  input  logic [7:0] reg_rd_data,
  output logic       busy
);

`ifdef SCCB_SLAVE_ACK_EN
  localparam logic ACK_DRIVE = 1'b1;
`else
  localparam logic ACK_DRIVE = 1'b0;
`endif

  typedef enum logic [3:0] {
    S_IDLE, S_ID, S_ID_X, S_SUB, S_SUB_X, S_WDATA, S_WDATA_X, S_RD, S_WAIT_STOP
  } state_t;

  state_t r_state, w_state_nxt;

  logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
  logic                   r_scl_d, r_sda_d;
  logic                   w_scl, w_sda;
  logic                   w_start, w_stop, w_rise, w_fall;

  logic [3:0] r_cnt, w_cnt_nxt;
  logic [7:0] r_shift, r_tx, r_addr, r_wdata;
  logic       r_oe, r_wr_en, r_busy;
  logic [7:0] w_byte;
  logic       w_last_bit, w_id_match, w_x_state, w_count_state;
  logic       w_oe_nxt, w_wr_en_nxt, w_busy_nxt;
  logic       w_shift_ld, w_addr_ld, w_wdata_ld, w_tx_ld, w_tx_shift;

  // Idle bus is high on both lines, so the synchronizers reset to 1.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], sio_c_in};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sio_d_in};
      r_scl_d    <= w_scl;
      r_sda_d    <= w_sda;
    end
  end

  assign w_scl   = r_scl_sync[SYNC_STAGES-1];
  assign w_sda   = r_sda_sync[SYNC_STAGES-1];
  assign w_start = r_scl_d & w_scl & r_sda_d & ~w_sda;
  assign w_stop  = r_scl_d & w_scl & ~r_sda_d & w_sda;
  assign w_rise  = ~r_scl_d & w_scl;
  assign w_fall  = r_scl_d & ~w_scl;

  assign w_byte        = {r_shift[6:0], w_sda};
  assign w_last_bit    = w_rise && (r_cnt == 4'd7);
  assign w_id_match    = (w_byte[7:1] == DEV_ADDRESS);
  assign w_x_state     = (r_state inside {S_ID_X, S_SUB_X, S_WDATA_X});
  assign w_count_state = (r_state inside {S_ID, S_ID_X, S_SUB, S_SUB_X, S_WDATA, S_WDATA_X, S_RD});

  always_ff @(posedge clk_in) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_stop) begin
      w_state_nxt = S_IDLE;
    end else if (w_start) begin
      w_state_nxt = S_ID;
    end else begin
      case (r_state)
        S_ID:      if (w_last_bit) w_state_nxt = w_id_match ? S_ID_X : S_WAIT_STOP;
        // r_shift[0] still holds the R/W bit during the ID acknowledge slot
        S_ID_X:    if (w_fall && r_cnt == 4'd9) w_state_nxt = r_shift[0] ? S_RD : S_SUB;
        S_SUB:     if (w_last_bit) w_state_nxt = S_SUB_X;
        S_SUB_X:   if (w_fall && r_cnt == 4'd9) w_state_nxt = S_WDATA;
        S_WDATA:   if (w_last_bit) w_state_nxt = S_WDATA_X;
        S_WDATA_X: if (w_fall && r_cnt == 4'd9) w_state_nxt = S_WAIT_STOP;
        S_RD:      if (w_fall && r_cnt == 4'd8) w_state_nxt = S_WAIT_STOP;
        default:   w_state_nxt = r_state;
      endcase
    end
  end

  always_comb begin
    w_oe_nxt    = 1'b0;
    w_wr_en_nxt = 1'b0;
    w_busy_nxt  = r_busy;
    w_cnt_nxt   = r_cnt;
    w_shift_ld  = 1'b0;
    w_addr_ld   = 1'b0;
    w_wdata_ld  = 1'b0;
    w_tx_ld     = 1'b0;
    w_tx_shift  = 1'b0;
    if (w_start || w_stop) begin
      w_cnt_nxt = '0;
      if (w_stop) w_busy_nxt = 1'b0;
    end else begin
      if (w_rise && (r_state inside {S_ID, S_SUB, S_WDATA})) w_shift_ld = 1'b1;
      if (w_rise && w_count_state) w_cnt_nxt = r_cnt + 4'd1;
      if (w_fall && w_x_state && r_cnt == 4'd9) w_cnt_nxt = '0;
      case (r_state)
        S_ID: if (w_last_bit) w_busy_nxt = w_id_match;
        S_ID_X: begin
          w_oe_nxt = r_oe;
          if (w_fall && r_cnt == 4'd8) begin
            w_oe_nxt = ACK_DRIVE;
          end else if (w_fall && r_cnt == 4'd9) begin
            // read: latch the byte and present bit 7 on the same fall
            w_tx_ld  = r_shift[0];
            w_oe_nxt = r_shift[0] & ~reg_rd_data[7];
          end
        end
        S_SUB: if (w_last_bit) w_addr_ld = 1'b1;
        S_SUB_X, S_WDATA_X: begin
          w_oe_nxt = r_oe;
          if (w_fall && r_cnt == 4'd8)      w_oe_nxt = ACK_DRIVE;
          else if (w_fall && r_cnt == 4'd9) w_oe_nxt = 1'b0;
        end
        S_WDATA: if (w_last_bit) begin
          w_wdata_ld  = 1'b1;
          w_wr_en_nxt = 1'b1;
        end
        S_RD: begin
          w_oe_nxt = r_oe;
          if (w_fall && r_cnt == 4'd8) begin
            w_oe_nxt = 1'b0;
          end else if (w_fall && r_cnt != 4'd0) begin
            w_tx_shift = 1'b1;
            w_oe_nxt   = ~r_tx[6];
          end
        end
        default: w_oe_nxt = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_cnt   <= '0;
      r_shift <= '0;
      r_tx    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_oe    <= 1'b0;
      r_wr_en <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_oe    <= w_oe_nxt;
      r_wr_en <= w_wr_en_nxt;
      r_busy  <= w_busy_nxt;
      if (w_shift_ld) r_shift <= w_byte;
      if (w_addr_ld)  r_addr  <= w_byte;
      if (w_wdata_ld) r_wdata <= w_byte;
      if (w_tx_ld)         r_tx <= reg_rd_data;
      else if (w_tx_shift) r_tx <= {r_tx[6:0], 1'b0};
    end
  end

  assign sio_d_oe    = r_oe;
  assign reg_addr    = r_addr;
  assign reg_wr_data = r_wdata;
  assign reg_wr_en   = r_wr_en;
  assign busy        = r_busy;

endmodule
